// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing with a fetch stream leading the display-aligned sync/de stream
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0,
  parameter int LOOKAHEAD = 2,
  parameter int COORD_W   = 12
) (
  input  logic               clk_pix,
  input  logic               rst,
  input  logic               en,
  output logic               fetch_valid,
  output logic [COORD_W-1:0] fetch_x,
  output logic [COORD_W-1:0] fetch_y,
  output logic               fetch_frame,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [COORD_W-1:0] h, v;
  logic hs_f, vs_f;
  logic [3:0] cur, dly;

  // Raster counters plus the registered fetch stage sampled from the current position
  always_ff @(posedge clk_pix or posedge rst)
    if (rst) begin
      h           <= '0;
      v           <= '0;
      fetch_x     <= '0;
      fetch_y     <= '0;
      fetch_valid <= 1'b0;
      fetch_frame <= 1'b0;
      hs_f        <= 1'b0;
      vs_f        <= 1'b0;
    end else if (en) begin
      h           <= (h == H_LAST) ? '0 : h + 1'b1;
      if (h == H_LAST) v <= (v == V_LAST) ? '0 : v + 1'b1;
      fetch_x     <= h;
      fetch_y     <= v;
      fetch_valid <= (h < H_ACT) && (v < V_ACT);
      fetch_frame <= (h == '0) && (v == '0);
      hs_f        <= (h >= HS_BEG) && (h < HS_END);
      vs_f        <= (v >= VS_BEG) && (v < VS_END);
    end

  assign cur = {hs_f, vs_f, fetch_valid, fetch_frame};

  generate
    if (LOOKAHEAD == 0) begin : g_comb
      assign dly = cur;
    end else begin : g_pipe
      logic [3:0] sr [LOOKAHEAD];
      // Delay line that holds sync/de back until the fetched pixel data catches up
      always_ff @(posedge clk_pix or posedge rst)
        if (rst) begin
          for (int i = 0; i < LOOKAHEAD; i++) sr[i] <= 4'b0;
        end else if (en) begin
          sr[0] <= cur;
          for (int i = 1; i < LOOKAHEAD; i++) sr[i] <= sr[i-1];
        end
      assign dly = sr[LOOKAHEAD-1];
    end
  endgenerate

  assign hsync       = dly[3] ~^ H_POL;
  assign vsync       = dly[2] ~^ V_POL;
  assign de          = dly[1];
  assign frame_start = dly[0];
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench for a default-width mode and a tiny wrap mode
module tb_video_timing_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic a_fv, a_ff, a_hs, a_vs, a_de, a_fs;
  logic [11:0] a_fx, a_fy;
  logic b_fv, b_ff, b_hs, b_vs, b_de, b_fs;
  logic [11:0] b_fx, b_fy;

  typedef struct packed {
    logic [29:0] a;
    logic [29:0] b;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [29:0] act_a, act_b;
  int n = 0;
  int vectors = 0;
  int miscompares = 0;

  // hand-written traces of one 40-clock frame of the tiny mode (8 clocks x 5 lines)
  string hs_s = "0000011000000110000001100000011000000110";
  string vs_s = "0000000000000000000000001111111100000000";
  string de_s = "1111000011110000000000000000000000000000";
  string fs_s = "1000000000000000000000000000000000000000";

  always #5 clk = ~clk;

  video_timing_gen #(
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_a (
    .clk_pix(clk), .rst(rst), .en(en),
    .fetch_valid(a_fv), .fetch_x(a_fx), .fetch_y(a_fy), .fetch_frame(a_ff),
    .hsync(a_hs), .vsync(a_vs), .de(a_de), .frame_start(a_fs)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .LOOKAHEAD(0)
  ) dut_b (
    .clk_pix(clk), .rst(rst), .en(en),
    .fetch_valid(b_fv), .fetch_x(b_fx), .fetch_y(b_fy), .fetch_frame(b_ff),
    .hsync(b_hs), .vsync(b_vs), .de(b_de), .frame_start(b_fs)
  );

  function automatic logic [29:0] pack(bit fv, bit ff, bit hs, bit vs, bit de, bit fs, int fx, int fy);
    return {fv, ff, hs, vs, de, fs, 12'(fx), 12'(fy)};
  endfunction

  // 800x8 raster, active-low syncs, display lags fetch by 2 enabled edges
  function automatic logic [29:0] model_a(int k);
    int p, q, dx, dy;
    int x = 0;
    int y = 0;
    bit fv = 0, ff = 0, hs = 1, vs = 1, de = 0, fs = 0;
    if (k > 0) begin
      p  = k - 1;
      x  = p % 800;
      y  = (p / 800) % 8;
      fv = (x < 640) && (y < 4);
      ff = (p % 6400) == 0;
    end
    if (k > 2) begin
      q  = k - 3;
      dx = q % 800;
      dy = (q / 800) % 8;
      hs = !((dx >= 656) && (dx < 752));
      vs = !((dy >= 5) && (dy < 7));
      de = (dx < 640) && (dy < 4);
      fs = (q % 6400) == 0;
    end
    return pack(fv, ff, hs, vs, de, fs, x, y);
  endfunction

  // 8x5 raster, active-high syncs, display aligned with fetch
  function automatic logic [29:0] model_b(int k);
    int p, f;
    int x = 0;
    int y = 0;
    bit fv = 0, ff = 0, hs = 0, vs = 0, de = 0, fs = 0;
    if (k > 0) begin
      p  = k - 1;
      x  = p % 8;
      y  = (p / 8) % 5;
      f  = p % 40;
      fv = (x < 4) && (y < 2);
      ff = f == 0;
      hs = hs_s[f] == "1";
      vs = vs_s[f] == "1";
      de = de_s[f] == "1";
      fs = fs_s[f] == "1";
    end
    return pack(fv, ff, hs, vs, de, fs, x, y);
  endfunction

  task automatic cyc(input bit r, input bit enable);
    @(negedge clk);
    rst = r;
    en  = enable;
    if (r) n = 0;
    else if (enable) n++;
    sb.push_back({model_a(n), model_b(n)});
  endtask

  // monitor: one expected entry per clock edge or asynchronous reset assertion
  initial forever begin
    @(posedge clk or posedge rst);
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      act_a = {a_fv, a_ff, a_hs, a_vs, a_de, a_fs, a_fx, a_fy};
      act_b = {b_fv, b_ff, b_hs, b_vs, b_de, b_fs, b_fx, b_fy};
      vectors++;
      if (act_a !== e.a) begin
        miscompares++;
        $display("FAIL dut_a t=%0t got {fv,ff,hs,vs,de,fs}=%b x=%0d y=%0d required %b x=%0d y=%0d",
                 $time, act_a[29:24], act_a[23:12], act_a[11:0], e.a[29:24], e.a[23:12], e.a[11:0]);
      end
      vectors++;
      if (act_b !== e.b) begin
        miscompares++;
        $display("FAIL dut_b t=%0t got {fv,ff,hs,vs,de,fs}=%b x=%0d y=%0d required %b x=%0d y=%0d",
                 $time, act_b[29:24], act_b[23:12], act_b[11:0], e.b[29:24], e.b[23:12], e.b[11:0]);
      end
    end
  end

  initial begin
    repeat (3) cyc(1, 1);
    repeat (6500) cyc(0, 1);
    while ((n - 1) % 800 != 639) cyc(0, 1);
    repeat (5) cyc(0, 0);
    repeat (10) cyc(0, 1);
    repeat (400) cyc(0, $urandom_range(3) != 0);
    repeat (300) cyc(0, 1);
    @(negedge clk);
    #2;
    n = 0;
    sb.push_back({model_a(0), model_b(0)});
    sb.push_back({model_a(0), model_b(0)});
    rst = 1'b1;
    repeat (2) cyc(1, 1);
    repeat (6500) cyc(0, 1);
    repeat (3) @(posedge clk);
    #4;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending entries required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
